// File: rtl/instruction_fetch_stage_pkg.sv
// Shared front-end constants and the per-edge fetch action decode.
package instruction_fetch_stage_pkg;

    localparam int unsigned ADDRESS_LEN_DEFAULT     = 32;
    localparam int unsigned INSTRUCTION_LEN_DEFAULT = 32;
    localparam int unsigned COUNTER_LEN_DEFAULT     = 16;
    localparam logic [31:0] NOP_INSTRUCTION         = 32'h0000_0000;
    localparam int unsigned PC_INCREMENT            = 4;
    localparam logic        ZERO                    = 1'b0;
    localparam logic        ONE                     = 1'b1;

    // What the fetch stage does on the next rising edge
    typedef enum logic [1:0] {
        ACT_FETCH  = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_FREEZE = 2'd2,
        ACT_BRANCH = 2'd3
    } fetch_action_e;

    // Branch beats freeze: the frozen ID instruction is on the wrong path
    function automatic fetch_action_e decode_action(input logic branch_taken,
                                                    input logic freeze,
                                                    input logic imem_ready);
        if (branch_taken)    return ACT_BRANCH;
        else if (freeze)     return ACT_FREEZE;
        else if (!imem_ready) return ACT_BUBBLE;
        else                 return ACT_FETCH;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction memory, IF/ID outputs.
// master = environment side (drives controls and memory data), slave = fetch stage.
interface instruction_fetch_stage_if
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned ADDRESS_LEN     = ADDRESS_LEN_DEFAULT,
    parameter int unsigned INSTRUCTION_LEN = INSTRUCTION_LEN_DEFAULT,
    parameter int unsigned COUNTER_LEN     = COUNTER_LEN_DEFAULT
);
    logic                       freeze;
    logic                       branch_taken;
    logic [ADDRESS_LEN-1:0]     branch_address;
    logic                       imem_ready;
    logic [INSTRUCTION_LEN-1:0] instr_in;
    logic [ADDRESS_LEN-1:0]     imem_addr;
    logic [ADDRESS_LEN-1:0]     if_id_pc;
    logic [INSTRUCTION_LEN-1:0] if_id_instruction;
    logic                       if_id_valid;
    logic [COUNTER_LEN-1:0]     bubble_count;

    modport master (
        output freeze, branch_taken, branch_address, imem_ready, instr_in,
        input  imem_addr, if_id_pc, if_id_instruction, if_id_valid, bubble_count
    );

    modport slave (
        input  freeze, branch_taken, branch_address, imem_ready, instr_in,
        output imem_addr, if_id_pc, if_id_instruction, if_id_valid, bubble_count
    );
endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds pc, instruction and valid for decode.
// Ports: clk, rst (async high), freeze, flush, load_bubble, pc_in, instr_in,
//        pc_out, instr_out, valid_out. Priority: flush > freeze > load_bubble > load.
module instruction_fetch_stage_if_id_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned ADDRESS_LEN     = ADDRESS_LEN_DEFAULT,
    parameter int unsigned INSTRUCTION_LEN = INSTRUCTION_LEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       load_bubble,
    input  logic [ADDRESS_LEN-1:0]     pc_in,
    input  logic [INSTRUCTION_LEN-1:0] instr_in,
    output logic [ADDRESS_LEN-1:0]     pc_out,
    output logic [INSTRUCTION_LEN-1:0] instr_out,
    output logic                       valid_out
);
    localparam logic [INSTRUCTION_LEN-1:0] NOP = INSTRUCTION_LEN'(NOP_INSTRUCTION);

    logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
    logic [INSTRUCTION_LEN-1:0] instr_q, instr_d;
    logic                       valid_q, valid_d;

    // Next-state selection
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush || (!freeze && load_bubble)) begin
            pc_d    = '0;
            instr_d = NOP;
            valid_d = ZERO;
        end else if (!freeze) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= ZERO;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// ARM fetch stage: PC register, PC+4, branch redirect, IF/ID register and a
// saturating bubble counter.
// Ports: clk, rst (async high), bus (slave): freeze, branch_taken,
//        branch_address, imem_ready, instr_in in; imem_addr, if_id_pc,
//        if_id_instruction, if_id_valid, bubble_count out.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned          ADDRESS_LEN     = ADDRESS_LEN_DEFAULT,
    parameter int unsigned          INSTRUCTION_LEN = INSTRUCTION_LEN_DEFAULT,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC      = '0,
    parameter int unsigned          COUNTER_LEN     = COUNTER_LEN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_stage_if.slave  bus
);
    logic [ADDRESS_LEN-1:0] pc_q, pc_d;
    logic [COUNTER_LEN-1:0] bubble_count_q, bubble_count_d;
    logic [ADDRESS_LEN-1:0] pc_plus4;
    logic [ADDRESS_LEN-1:0] branch_target;
    fetch_action_e          action;

    // Target low bits are dropped: instructions are word aligned
    logic unused_branch_low;
    assign unused_branch_low = ^bus.branch_address[1:0];

    assign action        = decode_action(bus.branch_taken, bus.freeze, bus.imem_ready);
    assign pc_plus4      = pc_q + ADDRESS_LEN'(PC_INCREMENT);
    assign branch_target = {bus.branch_address[ADDRESS_LEN-1:2], 2'b00};

    // PC redirect mux and saturating bubble counter
    always_comb begin
        pc_d           = pc_q;
        bubble_count_d = bubble_count_q;
        unique case (action)
            ACT_BRANCH: pc_d = branch_target;
            ACT_FETCH:  pc_d = pc_plus4;
            default:    pc_d = pc_q;
        endcase
        if ((action == ACT_BRANCH || action == ACT_BUBBLE) && (bubble_count_q != '1)) begin
            bubble_count_d = bubble_count_q + COUNTER_LEN'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= {RESET_PC[ADDRESS_LEN-1:2], 2'b00};
            bubble_count_q <= '0;
        end else begin
            pc_q           <= pc_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.imem_addr    = {pc_q[ADDRESS_LEN-1:2], 2'b00};
    assign bus.bubble_count = bubble_count_q;

    instruction_fetch_stage_if_id_register #(
        .ADDRESS_LEN     (ADDRESS_LEN),
        .INSTRUCTION_LEN (INSTRUCTION_LEN)
    ) if_id_register (
        .clk         (clk),
        .rst         (rst),
        .freeze      (bus.freeze),
        .flush       (bus.branch_taken),
        .load_bubble (!bus.imem_ready),
        .pc_in       (pc_plus4),
        .instr_in    (bus.instr_in),
        .pc_out      (bus.if_id_pc),
        .instr_out   (bus.if_id_instruction),
        .valid_out   (bus.if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with hand-computed expectations.
module tb_instruction_fetch_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    instruction_fetch_stage_if #(
        .ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .COUNTER_LEN(16)
    ) bus ();

    instruction_fetch_stage #(
        .ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .RESET_PC(32'h0), .COUNTER_LEN(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] addr,
                               input logic [31:0] pc, input logic [31:0] instr,
                               input logic valid, input logic [15:0] bubbles);
        check({tag, ".imem_addr"}, bus.imem_addr, addr);
        check({tag, ".if_id_pc"}, bus.if_id_pc, pc);
        check({tag, ".if_id_instr"}, bus.if_id_instruction, instr);
        check({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(valid));
        check({tag, ".bubbles"}, 32'(bus.bubble_count), 32'(bubbles));
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        bus.freeze         = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_address = 32'h0;
        bus.imem_ready     = 1'b1;
        bus.instr_in       = 32'hE3A0_1005;
        #2;
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        #10;
        rst = 1'b0;

        // Sequential fetch from reset
        tick(); check_state("fetch1", 32'h4, 32'h4, 32'hE3A0_1005, 1'b1, 16'd0);
        tick(); check_state("fetch2", 32'h8, 32'h8, 32'hE3A0_1005, 1'b1, 16'd0);
        tick(); check_state("fetch3", 32'hC, 32'hC, 32'hE3A0_1005, 1'b1, 16'd0);
        for (int i = 0; i < 5; i++) tick();
        check_state("to_0x20", 32'h20, 32'h20, 32'hE3A0_1005, 1'b1, 16'd0);

        // Freeze holds PC and IF/ID, no bubbles counted
        bus.freeze   = 1'b1;
        bus.instr_in = 32'hDEAD_BEEF;
        tick(); check_state("freeze1", 32'h20, 32'h20, 32'hE3A0_1005, 1'b1, 16'd0);
        tick(); check_state("freeze2", 32'h20, 32'h20, 32'hE3A0_1005, 1'b1, 16'd0);
        bus.freeze   = 1'b0;
        bus.instr_in = 32'h1111_1111;
        tick(); check_state("unfreeze", 32'h24, 32'h24, 32'h1111_1111, 1'b1, 16'd0);
        for (int i = 0; i < 7; i++) tick();
        check_state("to_0x40", 32'h40, 32'h40, 32'h1111_1111, 1'b1, 16'd0);

        // Branch with simultaneous freeze: branch wins, IF/ID flushed
        bus.branch_taken   = 1'b1;
        bus.branch_address = 32'h103;
        bus.freeze         = 1'b1;
        tick(); check_state("branch_freeze", 32'h100, 32'h0, 32'h0, 1'b0, 16'd1);
        bus.freeze         = 1'b0;

        // Redirect to 0x10, then memory not ready for three cycles
        bus.branch_address = 32'h10;
        tick(); check_state("branch_0x10", 32'h10, 32'h0, 32'h0, 1'b0, 16'd2);
        bus.branch_taken   = 1'b0;
        bus.imem_ready     = 1'b0;
        tick(); check_state("stall1", 32'h10, 32'h0, 32'h0, 1'b0, 16'd3);
        tick(); check_state("stall2", 32'h10, 32'h0, 32'h0, 1'b0, 16'd4);
        tick(); check_state("stall3", 32'h10, 32'h0, 32'h0, 1'b0, 16'd5);
        bus.imem_ready = 1'b1;
        bus.instr_in   = 32'hE082_2003;
        tick(); check_state("ready_back", 32'h14, 32'h14, 32'hE082_2003, 1'b1, 16'd5);

        // Branch to top of memory (low bits dropped), then wrap on fetch
        bus.branch_taken   = 1'b1;
        bus.branch_address = 32'hFFFF_FFFE;
        tick(); check_state("branch_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd6);
        bus.branch_taken   = 1'b0;
        tick(); check_state("wrap", 32'h0, 32'h0, 32'hE082_2003, 1'b1, 16'd6);

        // Long stall: counter saturates at 0xFFFF
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 65528; i++) tick();
        check("sat_pre", 32'(bus.bubble_count), 32'h0000_FFFE);
        tick(); check("sat_hit", 32'(bus.bubble_count), 32'h0000_FFFF);
        tick(); check("sat_hold", 32'(bus.bubble_count), 32'h0000_FFFF);
        for (int i = 0; i < 70000 - 65530; i++) tick();
        check_state("sat_long", 32'h0, 32'h0, 32'h0, 1'b0, 16'hFFFF);

        // One real fetch, then asynchronous reset between edges
        bus.imem_ready = 1'b1;
        tick(); check_state("pre_rst", 32'h4, 32'h4, 32'hE082_2003, 1'b1, 16'hFFFF);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        #1;
        rst = 1'b0;
        tick(); check_state("post_rst", 32'h4, 32'h4, 32'hE082_2003, 1'b1, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
